// File: rtl/rtl_feed_fifo_pkg.sv
// Shared definitions for the feed FIFO: default geometry, the stored entry
// layout, and the helper that builds an entry at enqueue time.
package rtl_feed_fifo_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int WIDTH_DEFAULT = 4;

  // One stored slot. The reductions of in1 are computed when the entry is
  // written, so the downstream stage gets them without a reduction tree on
  // the head path.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] in1;
    logic [WIDTH_DEFAULT-1:0] in2;
    logic                     orr;
    logic                     andr;
  } entry_t;

  // Build a stored entry from the operand pair presented at enqueue.
  function automatic entry_t make_entry(input logic [WIDTH_DEFAULT-1:0] a,
                                        input logic [WIDTH_DEFAULT-1:0] b);
    entry_t e;
    e.in1  = a;
    e.in2  = b;
    e.orr  = |a;
    e.andr = &a;
    return e;
  endfunction

endpackage : rtl_feed_fifo_pkg

// File: rtl/rtl_feed_fifo_if.sv
// Handshake bundle around the feed FIFO. The master side is the environment
// (producer plus downstream stage); the slave side is the FIFO itself.
// Member names match the FIFO's port names one for one.
interface rtl_feed_fifo_if
  import rtl_feed_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_in1;
  logic [WIDTH-1:0] enq_in2;
  logic             handshake_valid;
  logic             handshake_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             head_orr;
  logic             head_andr;

  modport master (
    output enq_valid, enq_in1, enq_in2, handshake_ready,
    input  enq_ready, handshake_valid, in1, in2, head_orr, head_andr
  );

  modport slave (
    input  enq_valid, enq_in1, enq_in2, handshake_ready,
    output enq_ready, handshake_valid, in1, in2, head_orr, head_andr
  );

endinterface : rtl_feed_fifo_if

// File: rtl/rtl_feed_fifo.sv
// Feed FIFO in front of a downstream RTL stage. Stores operand pairs with
// precomputed in1 reductions; one-cycle latency, no bypass. Pointers carry
// one extra wrap bit so full and empty are told apart without a counter.
module rtl_feed_fifo
  import rtl_feed_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
)(
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [WIDTH-1:0]         enq_in1,
  input  logic [WIDTH-1:0]         enq_in2,
  output logic                     handshake_valid,
  input  logic                     handshake_ready,
  output logic [WIDTH-1:0]         in1,
  output logic [WIDTH-1:0]         in2,
  output logic                     head_orr,
  output logic                     head_andr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // The entry layout lives in the shared package at the default width.
  if (WIDTH != WIDTH_DEFAULT) begin : g_width_guard
    $error("rtl_feed_fifo: WIDTH must equal WIDTH_DEFAULT of the package entry type");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_guard
    $error("rtl_feed_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;
  entry_t        r_mem [DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  entry_t        w_head;

  // Full: same slot address, opposite wrap bits. Empty: identical pointers.
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Flow control depends on registered pointers only, so there is no
  // combinational path from either handshake input to the other side.
  assign enq_ready       = !w_full;
  assign handshake_valid = !w_empty;
  assign w_push          = enq_valid && enq_ready;
  assign w_pop           = handshake_valid && handshake_ready;

  // Pointer difference modulo 2*DEPTH is exactly the occupancy 0..DEPTH.
  assign count        = r_wr_ptr - r_rd_ptr;
  assign overflow_err = r_overflow;

  // Pointer and sticky-error state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (enq_valid && !enq_ready) r_overflow <= 1'b1;
    end
  end

  // Storage write; reductions are folded into the entry here.
  // NOTE: the array has no reset -- stale slots are never visible because
  // the head is masked whenever the pointers say the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= make_entry(enq_in1, enq_in2);
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  // Head outputs: the stored head entry, forced to zero while empty.
  // NOTE: every output gets a default before the condition so no latch is
  // inferred on the empty path.
  always_comb begin
    in1       = '0;
    in2       = '0;
    head_orr  = 1'b0;
    head_andr = 1'b0;
    if (!w_empty) begin
      in1       = w_head.in1;
      in2       = w_head.in2;
      head_orr  = w_head.orr;
      head_andr = w_head.andr;
    end
  end

endmodule : rtl_feed_fifo

// File: tb/tb_rtl_feed_fifo.sv
// Scoreboard bench for rtl_feed_fifo. The stimulus side records accepted
// pairs in a queue-based reference model; a monitor on the falling edge
// compares whatever the FIFO presents at its head against the queue front.
module tb_rtl_feed_fifo;
  import rtl_feed_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtl_feed_fifo_if #(.WIDTH(WIDTH)) bus ();
  logic [CW-1:0] count;
  logic          overflow_err;

  rtl_feed_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK             (clk),
    .ASYNCRESETN     (rst_n),
    .enq_valid       (bus.enq_valid),
    .enq_ready       (bus.enq_ready),
    .enq_in1         (bus.enq_in1),
    .enq_in2         (bus.enq_in2),
    .handshake_valid (bus.handshake_valid),
    .handshake_ready (bus.handshake_ready),
    .in1             (bus.in1),
    .in2             (bus.in2),
    .head_orr        (bus.head_orr),
    .head_andr       (bus.head_andr),
    .count           (count),
    .overflow_err    (overflow_err)
  );

  // Reference model: a queue of accepted pairs plus a sticky error bit.
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } item_t;

  item_t q[$];
  item_t pend;
  bit    pend_v = 1'b0;
  bit    m_ovf  = 1'b0;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // An accepted pair becomes visible at the edge that ends its cycle.
  always @(posedge clk) begin
    if (pend_v && rst_n) begin
      q.push_back(pend);
      pend_v = 1'b0;
    end
  end

  // Monitor: compare the presented head with the oldest expected pair.
  always @(negedge clk) begin : mon
    item_t h;
    if (rst_n) begin
      check("handshake_valid", 32'(bus.handshake_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        check("head_in1",  32'(bus.in1),       32'(h.a));
        check("head_in2",  32'(bus.in2),       32'(h.b));
        check("head_orr",  32'(bus.head_orr),  32'(h.a != 0));
        check("head_andr", 32'(bus.head_andr), 32'(h.a == {WIDTH{1'b1}}));
        if (bus.handshake_ready) void'(q.pop_front());
      end else begin
        check("head_zero_when_empty",
              32'({bus.in1, bus.in2, bus.head_orr, bus.head_andr}), 32'(0));
      end
    end
  end

  // One bus cycle: check the registered status, record the model outcome
  // of the drive, apply it, and move to just after the next rising edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input bit r);
    check("count",        32'(count),         32'(q.size()));
    check("enq_ready",    32'(bus.enq_ready), 32'(q.size() != DEPTH));
    check("overflow_err", 32'(overflow_err),  32'(m_ovf));
    if (v && q.size() < DEPTH) begin
      pend   = '{a: a, b: b};
      pend_v = 1'b1;
    end
    if (v && q.size() >= DEPTH) m_ovf = 1'b1;
    bus.enq_valid       = v;
    bus.enq_in1         = a;
    bus.enq_in2         = b;
    bus.handshake_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},     32'(count),               32'(0));
    check({tag, "_valid"},     32'(bus.handshake_valid), 32'(0));
    check({tag, "_enq_ready"}, 32'(bus.enq_ready),       32'(1));
    check({tag, "_head"},
          32'({bus.in1, bus.in2, bus.head_orr, bus.head_andr}), 32'(0));
    check({tag, "_overflow"},  32'(overflow_err),        32'(0));
  endtask

  // Asynchronous reset in the middle of a cycle, released away from the edge.
  task automatic mid_reset();
    #2;
    rst_n  = 1'b0;
    q.delete();
    pend_v = 1'b0;
    m_ovf  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.enq_valid       = 1'b0;
    bus.handshake_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.enq_valid       = 1'b0;
    bus.enq_in1         = '0;
    bus.enq_in2         = '0;
    bus.handshake_ready = 1'b0;

    // Power-on reset.
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single push of F/3, observe it, then pop it.
    step(1'b1, 4'hF, 4'h3, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1);

    // Fill to full, then one extra push that must be dropped.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 4'(i + 8), 1'b0);
    step(1'b1, 4'h9, 4'h9, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0);

    // Pop and push together while full: push refused, then drain 2,3,4.
    step(1'b1, 4'h5, 4'h5, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0);

    // Reduction corners: all zeros, then a mixed pattern.
    step(1'b1, 4'h0, 4'h7, 1'b0);
    step(1'b1, 4'h6, 4'h2, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0);

    // Steady streaming across several pointer wraps.
    for (int i = 0; i < 20; i++) step(1'b1, 4'(i % 16), 4'(15 - (i % 16)), 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0);

    // Reset with three entries stored.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 10), 4'(i), 1'b0);
    mid_reset();
    step(1'b1, 4'hA, 4'h5, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1);

    // Randomised traffic with phases biased toward filling or draining.
    for (int ph = 0; ph < 10; ph++) begin
      int pv;
      int pr;
      pv = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 30 : 60;
      pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 90 : 60;
      for (int c = 0; c < 40; c++) begin
        step(($urandom_range(0, 99) < pv), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 99) < pr));
      end
    end

    // Drain whatever is left and confirm empty.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rtl_feed_fifo

// File: doc/rtl_feed_fifo.md
RTL_FEED_FIFO -- requirements
Module: rtl_feed_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of FIFO entries, a power of two and at least 2.
REQ-002 The block SHALL have parameter WIDTH, default 4: width of each operand.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port ASYNCRESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enq_valid, input, 1 bit: the producer presents an operand pair.
REQ-006 The block SHALL have port enq_ready, output, 1 bit: the FIFO can accept this cycle.
REQ-007 The block SHALL have port enq_in1, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port enq_in2, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port handshake_valid, output, 1 bit: the head entry is valid toward the downstream RTL stage.
REQ-010 The block SHALL have port handshake_ready, input, 1 bit: the downstream RTL stage accepts the head entry.
REQ-011 The block SHALL have port in1, output, WIDTH bits: head first operand.
REQ-012 The block SHALL have port in2, output, WIDTH bits: head second operand.
REQ-013 The block SHALL have port head_orr, output, 1 bit: OR-reduction of head in1, precomputed at enqueue.
REQ-014 The block SHALL have port head_andr, output, 1 bit: AND-reduction of head in1, precomputed at enqueue.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-016 The block SHALL have port overflow_err, output, 1 bit: sticky flag set by enq_valid held while full.

Function
REQ-017 A push SHALL occur when enq_valid && enq_ready; a pop SHALL occur when handshake_valid && handshake_ready.
REQ-018 enq_ready SHALL equal (count != DEPTH), combinational from registered state only, with no dependence on handshake_ready.
REQ-019 handshake_valid SHALL equal (count != 0), with no combinational path from the enq_* inputs.
REQ-020 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on handshake_valid/in1/in2 after edge N; there is no same-cycle bypass.
REQ-021 Each stored entry SHALL be {in1, in2, |in1, &in1}, with the reductions computed from enq_in1 at push time.
REQ-022 The head outputs in1, in2, head_orr and head_andr SHALL hold stable while handshake_valid && !handshake_ready.
REQ-023 When count == 0, the head outputs SHALL be driven 0.
REQ-024 Read and write pointers SHALL be clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
REQ-025 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 When full, push SHALL be blocked; a pop in the same cycle SHALL decrement count, and enq_ready SHALL rise in the next cycle.
REQ-027 When empty, no pop SHALL occur; a push SHALL make count 1.
REQ-028 Entries SHALL be delivered in strict FIFO order across pointer wrap-around.
REQ-029 overflow_err SHALL set at any edge where enq_valid && !enq_ready, and SHALL clear only on reset.

Reset
REQ-030 On ASYNCRESETN low, with immediate effect independent of CLK: both pointers = 0, count = 0, handshake_valid = 0, enq_ready = 1, head outputs = 0, overflow_err = 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared, since they are masked by count == 0.
REQ-032 Deassertion SHALL be taken synchronously to CLK; the first push is possible at the first edge after deassertion.

Structure
REQ-033 A shared package SHALL hold DEPTH_DEFAULT, WIDTH_DEFAULT, and the entry struct type {in1, in2, orr, andr}.
REQ-034 The storage array SHALL be a non-reset register array indexed by the pointer low bits.
REQ-035 The block SHALL be a single module with no sub-module; the downstream RTL stage connects by port names in1, in2, handshake_valid and handshake_ready.

Verification
REQ-036 Reset, then push in1=4'hF/in2=4'h3 -> next cycle handshake_valid=1, in1=F, in2=3, head_orr=1, head_andr=1, count=1.
REQ-037 Push 4 entries (in1 = 1, 2, 3, 4) with handshake_ready=0 -> count=4, enq_ready=0; a fifth enq_valid -> overflow_err=1, entry dropped.
REQ-038 Full FIFO, pop and push (in1=5) in the same cycle -> push refused, count=3; next cycle enq_ready=1; pops yield 2, 3, 4 in order.
REQ-039 Steady streaming with valid and ready high for 20 cycles, in1 = 0..19 mod 16 -> outputs in order, count stays 1, pointers wrap cleanly.
REQ-040 Push in1=4'h0 -> head_orr=0, head_andr=0; push in1=4'h6 -> head_orr=1, head_andr=0.
REQ-041 Assert ASYNCRESETN low mid-cycle with count=3 -> handshake_valid, count and head outputs all 0 before the next CLK edge.
